vc_arbiter: RTL and testbench
=============================

Name: vc_arbiter

Overview:
- Scheduler in front of the two-input VC mux: decides each cycle which virtual channel (VC0/VC1) pops its FIFO head and drives the shared destination.
- Weighted round-robin between VCs; stalls on destination back-pressure.
- Outputs registered data/valid to the destination and a pop strobe to each VC FIFO (first-word fall-through heads).

Parameters:
- BITNUMBER, 5, data width of each VC and of the destination.
- WEIGHT0, 2, maximum consecutive VC0 grants while VC1 has data (1..15).
- WEIGHT1, 1, maximum consecutive VC1 grants while VC0 has data (1..15).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- vc0_empty  input  1  VC0 FIFO empty flag.
- vc1_empty  input  1  VC1 FIFO empty flag.
- data_in0  input  BITNUMBER  VC0 FIFO head data.
- data_in1  input  BITNUMBER  VC1 FIFO head data.
- dest_pause  input  1  destination almost-full; no grant while high.
- pop_vc0  output  1  combinational pop strobe to VC0 FIFO.
- pop_vc1  output  1  combinational pop strobe to VC1 FIFO.
- data_out_dest  output  BITNUMBER  registered granted data.
- valid_out_dest  output  1  registered qualifier for data_out_dest.
- grant_vc1  output  1  registered: 1 = last grant went to VC1.
- idle_out  output  1  registered: state IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=RESET; all registered outputs 0; weight counters 0; pops forced 0.
- FSM states: RESET -> INIT (first edge with reset=1) -> IDLE/ACTIVE.
- INIT: one cycle; cnt0 <= WEIGHT0, cnt1 <= WEIGHT1, last=VC1 (so VC0 wins the first contention); no pops.
- IDLE: both empty. Go ACTIVE when either is non-empty; idle_out=1 only here.
- ACTIVE: grant decision every cycle. Return to IDLE on the edge where both FIFOs are empty and no pop occurs.
- Grant eligibility: pop occurs only if state=ACTIVE, dest_pause=0, and the chosen VC is non-empty. At most one pop per cycle; pop_vc0 and pop_vc1 are never both 1.
- Choice when only one VC is non-empty: that VC; its counter is not decremented, and the other counter is reloaded.
- Choice when both are non-empty: the current owner keeps the grant while its counter > 0, decrementing by 1 per grant.
  - When the owner's counter reaches 0, ownership passes to the other VC and the exhausted counter reloads to its WEIGHT.
  - Initial owner after INIT is VC0.
- Counters are 4-bit and saturate at 0 (never wrap).
- Datapath, latency 1: on a pop edge, data_out_dest <= selected head, valid_out_dest <= 1, grant_vc1 <= (VC1 selected).
  - On non-pop edges valid_out_dest <= 0; data_out_dest and grant_vc1 hold.
- dest_pause high: pops drop in the same cycle (combinational); counters and owner are frozen; valid_out_dest falls on the next edge.
- Reset mid-burst: all outputs clear immediately; the sequence restarts through INIT; no pop is asserted during RESET or INIT.
- Empty flag rising in the same cycle as a planned pop: the pop is suppressed, since eligibility uses the current flag.

Optional Feature:
- Macro VC0_STRICT_PRIORITY_EN.
- Defined: weights are ignored; VC0 is granted whenever it is non-empty, and VC1 only when VC0 is empty. Counters are not synthesized and INIT only clears state.
- Undefined: the weighted round-robin above.

Test Plan:
- Reset/INIT: reset=0 for 2 cycles, then 1 -> all outputs 0 during reset; no pop in the INIT cycle; idle_out=1 on the following edge with both FIFOs empty.
- Single VC: VC1 holds 3 words (7,8,9), VC0 empty -> pop_vc1 for 3 consecutive cycles; data_out_dest = 7,8,9 with valid_out_dest=1 one cycle after each pop; grant_vc1=1.
- Contention, WEIGHT0=2 and WEIGHT1=1, both FIFOs deep -> grant pattern VC0,VC0,VC1,VC0,VC0,VC1 repeating; never two pops in one cycle.
- Back-pressure: dest_pause=1 mid-burst for 3 cycles -> pops are 0 in those cycles and valid_out_dest=0 from the next edge; after release, the pattern resumes at the frozen counter position.
- Reset mid-burst: reset=0 while valid_out_dest=1 -> valid_out_dest=0 immediately; after release, first grant on contention goes to VC0.
- With VC0_STRICT_PRIORITY_EN, both FIFOs non-empty for 5 cycles -> only pop_vc0 asserts; VC1 is granted only once vc0_empty=1.

Source files
------------

// File: rtl/vc_arbiter_if.sv
// Signal bundle between the two VC FIFO heads, the arbiter and the shared destination.
interface vc_arbiter_if #(
    parameter int BITNUMBER = 5
);
    logic                 vc0_empty;
    logic                 vc1_empty;
    logic [BITNUMBER-1:0] data_in0;
    logic [BITNUMBER-1:0] data_in1;
    logic                 dest_pause;
    logic                 pop_vc0;
    logic                 pop_vc1;
    logic [BITNUMBER-1:0] data_out_dest;
    logic                 valid_out_dest;
    logic                 grant_vc1;
    logic                 idle_out;

    // Environment side: FIFOs and destination
    modport master (
        output vc0_empty, vc1_empty, data_in0, data_in1, dest_pause,
        input  pop_vc0, pop_vc1, data_out_dest, valid_out_dest, grant_vc1, idle_out
    );

    // Arbiter side
    modport slave (
        input  vc0_empty, vc1_empty, data_in0, data_in1, dest_pause,
        output pop_vc0, pop_vc1, data_out_dest, valid_out_dest, grant_vc1, idle_out
    );
endinterface

// File: rtl/vc_arbiter.sv
// Two-VC weighted round-robin scheduler: combinational FIFO pops, registered destination outputs.
// Define VC0_STRICT_PRIORITY_EN to replace the weighting with fixed VC0 priority.
module vc_arbiter #(
    parameter int BITNUMBER = 5,
    parameter int WEIGHT0   = 2,
    parameter int WEIGHT1   = 1
) (
    input  logic        clk,
    input  logic        reset,
    vc_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 sel_vc1_s;
    logic                 grant_ok_s;
    logic                 pop0_s;
    logic                 pop1_s;
    logic                 any_pop_s;
    logic                 both_empty_s;
    logic [BITNUMBER-1:0] data_r;
    logic                 valid_r;
    logic                 grant_vc1_r;
    logic                 idle_r;

    assign both_empty_s = bus.vc0_empty & bus.vc1_empty;
    // Eligibility uses the live empty flags, so a head emptying this cycle is never popped
    assign grant_ok_s   = (state_r == ST_ACTIVE) & ~bus.dest_pause;
    assign pop0_s       = grant_ok_s & ~sel_vc1_s & ~bus.vc0_empty;
    assign pop1_s       = grant_ok_s &  sel_vc1_s & ~bus.vc1_empty;
    assign any_pop_s    = pop0_s | pop1_s;

`ifdef VC0_STRICT_PRIORITY_EN
    assign sel_vc1_s = bus.vc0_empty;
`else
    localparam logic [3:0] W0_C = 4'(WEIGHT0);
    localparam logic [3:0] W1_C = 4'(WEIGHT1);

    logic [3:0] cnt0_r;
    logic [3:0] cnt1_r;
    logic [3:0] cnt0_nxt_s;
    logic [3:0] cnt1_nxt_s;
    logic       owner_r;
    logic       owner_nxt_s;

    // Weighted choice; owner_r = 1 means VC1 holds the grant under contention
    always_comb begin
        sel_vc1_s   = 1'b0;
        cnt0_nxt_s  = cnt0_r;
        cnt1_nxt_s  = cnt1_r;
        owner_nxt_s = owner_r;
        if (!bus.vc0_empty && !bus.vc1_empty) begin
            sel_vc1_s = owner_r;
            if (owner_r) begin
                if (cnt1_r > 4'd1) begin
                    cnt1_nxt_s = cnt1_r - 4'd1;
                end else begin
                    cnt1_nxt_s  = W1_C;
                    owner_nxt_s = 1'b0;
                end
            end else begin
                if (cnt0_r > 4'd1) begin
                    cnt0_nxt_s = cnt0_r - 4'd1;
                end else begin
                    cnt0_nxt_s  = W0_C;
                    owner_nxt_s = 1'b1;
                end
            end
        end else if (!bus.vc1_empty) begin
            sel_vc1_s  = 1'b1;
            cnt0_nxt_s = W0_C;
        end else begin
            sel_vc1_s  = 1'b0;
            cnt1_nxt_s = W1_C;
        end
    end

    // Weight counters and owner: loaded in INIT, advanced only on a real pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0_r  <= 4'd0;
            cnt1_r  <= 4'd0;
            owner_r <= 1'b0;
        end else if (state_r == ST_INIT) begin
            cnt0_r  <= W0_C;
            cnt1_r  <= W1_C;
            owner_r <= 1'b0;
        end else if (any_pop_s) begin
            cnt0_r  <= cnt0_nxt_s;
            cnt1_r  <= cnt1_nxt_s;
            owner_r <= owner_nxt_s;
        end else begin
            cnt0_r  <= cnt0_r;
            cnt1_r  <= cnt1_r;
            owner_r <= owner_r;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RESET:  state_nxt_s = ST_INIT;
            ST_INIT:   state_nxt_s = both_empty_s ? ST_IDLE : ST_ACTIVE;
            ST_IDLE:   state_nxt_s = both_empty_s ? ST_IDLE : ST_ACTIVE;
            ST_ACTIVE: state_nxt_s = (both_empty_s && !any_pop_s) ? ST_IDLE : ST_ACTIVE;
            default:   state_nxt_s = ST_RESET;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Destination outputs: one-cycle latency behind the pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_r      <= {BITNUMBER{1'b0}};
            valid_r     <= 1'b0;
            grant_vc1_r <= 1'b0;
            idle_r      <= 1'b0;
        end else begin
            valid_r <= any_pop_s;
            idle_r  <= (state_nxt_s == ST_IDLE);
            if (any_pop_s) begin
                data_r      <= sel_vc1_s ? bus.data_in1 : bus.data_in0;
                grant_vc1_r <= pop1_s;
            end else begin
                data_r      <= data_r;
                grant_vc1_r <= grant_vc1_r;
            end
        end
    end

    assign bus.pop_vc0        = pop0_s;
    assign bus.pop_vc1        = pop1_s;
    assign bus.data_out_dest  = data_r;
    assign bus.valid_out_dest = valid_r;
    assign bus.grant_vc1      = grant_vc1_r;
    assign bus.idle_out       = idle_r;
endmodule

// File: tb/tb_vc_arbiter.sv
// Scoreboard bench for vc_arbiter: FIFO model drives heads, a monitor checks every valid output.
module tb_vc_arbiter;
    localparam int BW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vc_arbiter_if #(.BITNUMBER(BW)) bus ();
    vc_arbiter #(.BITNUMBER(BW), .WEIGHT0(2), .WEIGHT1(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    logic [BW-1:0] sh0[$];
    logic [BW-1:0] sh1[$];
    logic [BW:0]   exp_q[$];
    int            n_pass = 0;
    int            n_total = 0;
    logic          last_p0 = 1'b0;
    logic          last_p1 = 1'b0;

    // Hand-derived grant sequences: per cycle 0 = no pop, 1 = VC0, 2 = VC1
`ifdef VC0_STRICT_PRIORITY_EN
    string pre_s   = "01111111";
    string post_s  = "122220";
    string rpre_s  = "01";
    string rpost_s = "00112220";
`else
    string pre_s   = "01121121";
    string post_s  = "121120";
    string rpre_s  = "02";
    string rpost_s = "00112120";
`endif

    function automatic void check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endfunction

    task automatic drive();
        bus.vc0_empty = (q0.size() == 0);
        bus.vc1_empty = (q1.size() == 0);
        bus.data_in0  = (q0.size() != 0) ? q0[0] : 5'd0;
        bus.data_in1  = (q1.size() != 0) ? q1[0] : 5'd0;
    endtask

    // One clock: sample pops mid-cycle, retire popped heads just after the edge
    task automatic tick();
        @(negedge clk);
        last_p0 = bus.pop_vc0;
        last_p1 = bus.pop_vc1;
        @(posedge clk);
        #1;
        if (last_p0 && q0.size() != 0) void'(q0.pop_front());
        if (last_p1 && q1.size() != 0) void'(q1.pop_front());
        drive();
    endtask

    task automatic run_pops(input string name, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            tick();
            check($sformatf("%s_pop[%0d]", name, i), int'({last_p1, last_p0}), int'(pat[i]) - 48);
        end
    endtask

    // Push the outputs a grant sequence must produce onto the scoreboard
    task automatic plan(input string pat, input bit scored);
        logic [BW-1:0] d;
        for (int i = 0; i < pat.len(); i++) begin
            if (pat[i] == "1") begin
                d = sh0.pop_front();
                if (scored) exp_q.push_back({1'b0, d});
            end else if (pat[i] == "2") begin
                d = sh1.pop_front();
                if (scored) exp_q.push_back({1'b1, d});
            end
        end
    endtask

    task automatic monitor();
        logic [BW:0] e;
        forever begin
            @(negedge clk);
            if (reset && bus.valid_out_dest) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", int'(bus.data_out_dest), int'(e[BW-1:0]));
                    check("sb_grant_vc1", int'(bus.grant_vc1), int'(e[BW]));
                end
            end
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.dest_pause = 1'b0;
        drive();
        fork
            monitor();
        join_none

        tick();
        tick();
        check("rst_valid", bus.valid_out_dest, 0);
        check("rst_data", bus.data_out_dest, 0);
        check("rst_grant", bus.grant_vc1, 0);
        check("rst_idle", bus.idle_out, 0);
        reset = 1'b1;
        tick();
        check("init_idle", bus.idle_out, 0);
        tick();
        check("idle_after_init", bus.idle_out, 1);

        for (int i = 0; i < 3; i++) begin
            q1.push_back(5'(7 + i));
            sh1.push_back(5'(7 + i));
        end
        drive();
        plan("02220", 1'b1);
        run_pops("single", "02220");
        check("single_idle", bus.idle_out, 1);

        for (int i = 0; i < 8; i++) begin
            q0.push_back(5'(1 + i));
            sh0.push_back(5'(1 + i));
        end
        for (int i = 0; i < 4; i++) begin
            q1.push_back(5'(20 + i));
            sh1.push_back(5'(20 + i));
        end
        drive();
        plan(pre_s, 1'b1);
        run_pops("contend", pre_s);
        check("contend_valid", bus.valid_out_dest, 1);
        bus.dest_pause = 1'b1;
        run_pops("pause", "0");
        check("pause_valid", bus.valid_out_dest, 0);
        run_pops("pause_hold", "00");
        bus.dest_pause = 1'b0;
        plan(post_s, 1'b1);
        run_pops("resume", post_s);
        check("contend_idle", bus.idle_out, 1);

        for (int i = 0; i < 3; i++) begin
            q0.push_back(5'(1 + i));
            sh0.push_back(5'(1 + i));
            q1.push_back(5'(24 + i));
            sh1.push_back(5'(24 + i));
        end
        drive();
        plan(rpre_s, 1'b0);
        run_pops("pre_rst", rpre_s);
        check("pre_rst_valid", bus.valid_out_dest, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid", bus.valid_out_dest, 0);
        check("mid_rst_data", bus.data_out_dest, 0);
        check("mid_rst_grant", bus.grant_vc1, 0);
        check("mid_rst_pops", int'({bus.pop_vc1, bus.pop_vc0}), 0);
        run_pops("in_rst", "0");
        reset = 1'b1;
        plan(rpost_s, 1'b1);
        run_pops("post_rst", rpost_s);
        check("post_rst_idle", bus.idle_out, 1);

        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
